// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the instruction/data memory port arbiter:
//   - arb_state_e : arbiter FSM states
//   - F3_*        : RV32 funct3 access size/sign encodings for loads and stores
//   - BE_*        : common byte-enable patterns
//   - is_misaligned() : alignment check from access size and address low bits
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_WAIT = 2'd1,
        ST_D_WAIT  = 2'd2
    } arb_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // size is funct3[1:0]: 00 byte, 01 half, anything else is a word access
    // (loads 011/110/111 behave as lw, so they need word alignment too).
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = addr_lo[0];
            default: bad = (addr_lo != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Combinational lane handling for the data port.
//   Store side (live request): byte/half replication across lanes, byte-enable
//   generation and alignment check.
//   Load side (latched access): lane extraction plus sign/zero extension.
// Ports:
//   req_size_i    [1:0]  funct3[1:0] of the live data request
//   req_addr_lo_i [1:0]  low address bits of the live data request
//   st_wdata_i    [31:0] right-aligned store data
//   ld_f3_i       [2:0]  funct3 of the latched load
//   ld_addr_lo_i  [1:0]  low address bits of the latched load
//   ld_rdata_i    [31:0] raw memory word
//   st_be_o       [3:0]  store byte enables
//   st_wdata_o    [31:0] lane-steered store data
//   misalign_o           live request is misaligned
//   ld_data_o     [31:0] extracted and extended load data
// -----------------------------------------------------------------------------
module lsu_align
    import mem_arb_pkg::*;
(
    input  logic [1:0]  req_size_i,
    input  logic [1:0]  req_addr_lo_i,
    input  logic [31:0] st_wdata_i,
    input  logic [2:0]  ld_f3_i,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic [31:0] ld_rdata_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,
    output logic        misalign_o,
    output logic [31:0] ld_data_o
);

    logic [7:0]  ld_byte_s;
    logic [15:0] ld_half_s;

    assign misalign_o = is_misaligned(req_size_i, req_addr_lo_i);

    // Store lane steering: data is replicated so any enabled lane sees it
    always_comb begin
        st_be_o    = BE_WORD;
        st_wdata_o = st_wdata_i;
        case (req_size_i)
            F3_SB[1:0]: begin
                st_be_o    = 4'b0001 << req_addr_lo_i;
                st_wdata_o = {4{st_wdata_i[7:0]}};
            end
            F3_SH[1:0]: begin
                st_be_o    = req_addr_lo_i[1] ? BE_HALF_HI : BE_HALF_LO;
                st_wdata_o = {2{st_wdata_i[15:0]}};
            end
            F3_SW[1:0]: begin
                st_be_o    = BE_WORD;
                st_wdata_o = st_wdata_i;
            end
            default: begin
                st_be_o    = BE_WORD;
                st_wdata_o = st_wdata_i;
            end
        endcase
    end

    // Load lane selection by latched address
    always_comb begin
        ld_half_s = ld_addr_lo_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
        case (ld_addr_lo_i)
            2'b00:   ld_byte_s = ld_rdata_i[7:0];
            2'b01:   ld_byte_s = ld_rdata_i[15:8];
            2'b10:   ld_byte_s = ld_rdata_i[23:16];
            2'b11:   ld_byte_s = ld_rdata_i[31:24];
            default: ld_byte_s = ld_rdata_i[7:0];
        endcase
    end

    // Load extension by funct3; unlisted encodings read the full word
    always_comb begin
        case (ld_f3_i)
            F3_LB:   ld_data_o = {{24{ld_byte_s[7]}}, ld_byte_s};
            F3_LH:   ld_data_o = {{16{ld_half_s[15]}}, ld_half_s};
            F3_LBU:  ld_data_o = {24'h000000, ld_byte_s};
            F3_LHU:  ld_data_o = {16'h0000, ld_half_s};
            F3_LW:   ld_data_o = ld_rdata_i;
            default: ld_data_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-outstanding memory port between instruction fetch and the
// load/store unit. Data requests win in IDLE; acks are registered one-cycle
// pulses and no new access is granted in an ack cycle, so a requester still
// holding its request while it sees the ack is not served twice.
// Optional feature macro: ARB_STARVE_GUARD_EN
//   defined   : after STARVE_LIMIT consecutive data grants with fetch waiting,
//               the next grant goes to fetch (STARVE_LIMIT parameter exists
//               only in this build)
//   undefined : strict data priority
// Ports:
//   clk, rst (sync, active-high)
//   if_req/if_addr -> if_ack/if_rdata                 fetch port
//   d_r_en/d_w_en/d_add/d_wdata/f3 -> d_ack/d_rdata/d_misalign, stall   data
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata, mem_ready/mem_rdata      memory
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
`ifdef ARB_STARVE_GUARD_EN
#(
    parameter int unsigned STARVE_LIMIT = 4
)
`endif
(
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_r_en,
    input  logic        d_w_en,
    input  logic [31:0] d_add,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  f3,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_misalign,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    arb_state_e  state_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic        if_ack_q;
    logic        d_ack_q;
    logic        d_misalign_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [2:0]  ld_f3_q;
    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;

    logic        d_pend_s;
    logic        ack_busy_s;
    logic        take_data_s;
    logic        misalign_s;
    logic [3:0]  st_be_s;
    logic [31:0] st_wdata_s;
    logic [31:0] ld_data_s;

    assign d_pend_s   = d_r_en | d_w_en;
    assign ack_busy_s = if_ack_q | d_ack_q;

    lsu_align u_lsu_align (
        .req_size_i    (f3[1:0]),
        .req_addr_lo_i (d_add[1:0]),
        .st_wdata_i    (d_wdata),
        .ld_f3_i       (ld_f3_q),
        .ld_addr_lo_i  (addr_q[1:0]),
        .ld_rdata_i    (mem_rdata),
        .st_be_o       (st_be_s),
        .st_wdata_o    (st_wdata_s),
        .misalign_o    (misalign_s),
        .ld_data_o     (ld_data_s)
    );

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned      CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             idle_grant_s;

    assign idle_grant_s = (state_q == ST_IDLE) && !ack_busy_s;
    assign take_data_s  = d_pend_s && !(if_req && (starve_cnt_q >= STARVE_MAX));

    // Count data services while fetch waits; any fetch grant or idle fetch clears.
    // The count cannot pass STARVE_MAX: at the limit a waiting fetch wins.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (idle_grant_s && take_data_s) begin
            if (if_req) begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end else begin
                starve_cnt_d = {CNT_W{1'b0}};
            end
        end else if (idle_grant_s && if_req) begin
            starve_cnt_d = {CNT_W{1'b0}};
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= {CNT_W{1'b0}};
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign take_data_s = d_pend_s;
`endif

    // Arbiter FSM with registered memory-side and requester-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            d_misalign_q <= 1'b0;
            addr_q       <= 32'h0000_0000;
            wdata_q      <= 32'h0000_0000;
            be_q         <= BE_NONE;
            ld_f3_q      <= 3'b000;
            if_rdata_q   <= 32'h0000_0000;
            d_rdata_q    <= 32'h0000_0000;
        end else begin
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            d_misalign_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!ack_busy_s) begin
                        if (take_data_s) begin
                            if (misalign_s) begin
                                // Rejected without touching memory
                                d_ack_q      <= 1'b1;
                                d_misalign_q <= 1'b1;
                                d_rdata_q    <= 32'h0000_0000;
                            end else begin
                                state_q   <= ST_D_WAIT;
                                mem_req_q <= 1'b1;
                                mem_we_q  <= d_w_en;
                                addr_q    <= d_add;
                                ld_f3_q   <= f3;
                                be_q      <= d_w_en ? st_be_s : BE_WORD;
                                wdata_q   <= d_w_en ? st_wdata_s : 32'h0000_0000;
                            end
                        end else if (if_req) begin
                            state_q   <= ST_IF_WAIT;
                            mem_req_q <= 1'b1;
                            mem_we_q  <= 1'b0;
                            addr_q    <= if_addr;
                            be_q      <= BE_WORD;
                            wdata_q   <= 32'h0000_0000;
                        end
                    end
                end
                ST_IF_WAIT: begin
                    if (mem_ready) begin
                        state_q    <= ST_IDLE;
                        mem_req_q  <= 1'b0;
                        if_ack_q   <= 1'b1;
                        if_rdata_q <= mem_rdata;
                    end
                end
                ST_D_WAIT: begin
                    if (mem_ready) begin
                        state_q   <= ST_IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        d_ack_q   <= 1'b1;
                        d_rdata_q <= mem_we_q ? 32'h0000_0000 : ld_data_s;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign if_ack     = if_ack_q;
    assign if_rdata   = if_rdata_q;
    assign d_ack      = d_ack_q;
    assign d_rdata    = d_rdata_q;
    assign d_misalign = d_misalign_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign mem_be     = be_q;
    assign mem_wdata  = wdata_q;
    // Follows the live request so the pipeline holds in the request cycle itself
    assign stall      = d_pend_s & ~d_ack_q & ~rst;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, max consecutive data grants while fetch waits (used only with ARB_STARVE_GUARD_EN).
REQ-002 clk  input  1  clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 if_req  input  1  instruction-fetch request, held high until if_ack.
REQ-005 if_addr  input  32  fetch byte address, word-aligned.
REQ-006 if_ack  output  1  one-cycle pulse, if_rdata valid.
REQ-007 if_rdata  output  32  fetched word.
REQ-008 d_r_en / d_w_en  input  1 each  data load/store request from execute stage, held until d_ack.
REQ-009 d_add  input  32  data byte address.
REQ-010 d_wdata  input  32  store data, right-aligned.
REQ-011 f3  input  3  RV32 funct3 access size/sign.
REQ-012 d_ack  output  1  one-cycle pulse, load data/status valid.
REQ-013 d_rdata  output  32  load data, lane-extracted and extended.
REQ-014 d_misalign  output  1  qualified by d_ack; access rejected.
REQ-015 stall  output  1  high while a data request is pending and d_ack not yet given.
REQ-016 mem_req, mem_we  output  1 each; mem_addr  output  32 (bits [1:0]=0); mem_be  output  4; mem_wdata  output  32.
REQ-017 mem_ready  input  1; mem_rdata  input  32; one access completes per mem_ready cycle.

Function
REQ-018 FSM states IDLE, IF_WAIT, D_WAIT; exactly one outstanding memory access.
REQ-019 IDLE: data request pending -> latch data request, go D_WAIT; else if_req -> latch fetch, go IF_WAIT; else stay.
REQ-020 In WAIT states mem_req=1 and latched address/be/wdata/we held stable until mem_ready.
REQ-021 mem_ready in WAIT state -> registered ack (+ rdata) pulses next cycle, FSM returns IDLE on same edge; no access issued in ack cycle.
REQ-022 Minimum latency: request at cycle N, mem_req at N+1, mem_ready at N+1 -> ack at N+2.
REQ-023 d_r_en and d_w_en both high -> store performed.
REQ-024 Store: sb: byte replicated to all lanes, mem_be one-hot at d_add[1:0]; sh: halfword in both halves, mem_be 0011/1100 by d_add[1]; sw: mem_be 1111.
REQ-025 Load f3: 000 lb sign-ext, 001 lh sign-ext, 010 lw, 100 lbu zero-ext, 101 lhu zero-ext; 011/110/111 treated as lw; mem_be 1111, mem_we 0.
REQ-026 Misaligned (half with d_add[0]=1, word with d_add[1:0]!=0): no memory access; d_ack and d_misalign pulse next cycle, d_rdata 0, FSM stays IDLE.
REQ-027 Request inputs changing during WAIT have no effect; only latched values used.

Reset
REQ-028 On rst: FSM IDLE; if_ack, d_ack, d_misalign, mem_req, mem_we, stall 0; mem_addr, mem_be, mem_wdata, if_rdata, d_rdata 0; starvation counter 0.
REQ-029 rst mid-access abandons it; mem_req low next cycle; no ack issued for abandoned access.

Configuration
REQ-030 Macro ARB_STARVE_GUARD_EN defined: counter of consecutive data grants while if_req high; at STARVE_LIMIT next IDLE grant goes to fetch, counter clears on any fetch grant.
REQ-031 ARB_STARVE_GUARD_EN undefined: strict data priority, no counter logic.

Structure
REQ-032 Package mem_arb_pkg: FSM state enum, funct3 size constants (LB..LHU, SB..SW), BE constants.
REQ-033 Sub-module lsu_align: combinational store lane steering/BE generation and load extraction/extension, instantiated once.

Verification
REQ-034 Fetch only: if_addr 0x100, mem_ready same cycle as mem_req, mem_rdata 0xDEADBEEF -> if_ack at N+2, if_rdata 0xDEADBEEF.
REQ-035 Simultaneous if_req and d_r_en in IDLE -> data served first, fetch next; stall high until d_ack.
REQ-036 lb at 0x203, mem_rdata 0x80FFFFFF -> d_rdata 0xFFFFFF80; lbu same -> 0x00000080.
REQ-037 sh at 0x202, d_wdata 0x1234ABCD -> mem_be 1100, mem_wdata 0xABCDABCD, mem_we 1.
REQ-038 sw at 0x101 -> no mem_req, d_ack and d_misalign pulse next cycle, d_rdata 0.
REQ-039 With ARB_STARVE_GUARD_EN, STARVE_LIMIT=4, continuous data requests and if_req -> fetch granted after 4th data ack; rst during D_WAIT -> mem_req low next cycle, no d_ack.
